// File: rtl/rv32m_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes and FSM states.
package rv32m_muldiv_seq_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rv32m_muldiv_seq_if.sv
// EX-stage request/response bundle for the multi-cycle RV32M unit.
interface rv32m_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, rd_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/rv32m_muldiv_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module rv32m_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc_next
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     top;
  logic [XLEN-1:0]   trial;
  logic [XLEN:0]     add_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_next = acc_q;
    top      = '0;
    trial    = '0;
    add_sum  = '0;
    if (is_div) begin
      // Upper half after the left shift; the trial difference always fits XLEN bits when kept.
      top   = acc_q[2*XLEN-1:XLEN-1];
      trial = top[XLEN-1:0] - b_q;
      if (top >= {1'b0, b_q}) acc_next = {trial, acc_q[XLEN-2:0], 1'b1};
      else                    acc_next = {top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      acc_next = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before they are read.
  always_ff @(posedge clk_i) begin
    if (load) begin
      acc_q <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_seq.sv
// RV32M sequencer: FSM, iteration counter, shortcut detection and sign fix-up around the core.
module rv32m_muldiv_seq
  import rv32m_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk_i,
  input logic               reset_i,
  rv32m_muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        f3_q;
  logic              neg_res_q, neg_rem_q;
  logic [XLEN-1:0]   stage_q, result_q;
  logic [4:0]        stage_rd_q, rd_hold_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, accept;
  logic [XLEN-1:0]   a_mag, b_mag, short_res, final_res;
  logic [2*XLEN-1:0] acc_next, prod;

  always_comb begin
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    short_res = '0;
    case (bus.funct3_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      F3_MULHSU:                       a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & bus.op_a_i[XLEN-1];
    b_neg    = b_signed & bus.op_b_i[XLEN-1];
    a_mag    = a_neg ? -bus.op_a_i : bus.op_a_i;
    b_mag    = b_neg ? -bus.op_b_i : bus.op_b_i;
    div_zero = bus.funct3_i[2] && (bus.op_b_i == '0);
    div_ovf  = (bus.funct3_i == F3_DIV || bus.funct3_i == F3_REM) &&
               (bus.op_a_i == MIN_VAL) && (bus.op_b_i == '1);
    case (bus.funct3_i)
      F3_DIV:  short_res = div_zero ? '1 : MIN_VAL;
      F3_DIVU: short_res = '1;
      F3_REM:  short_res = div_zero ? bus.op_a_i : '0;
      F3_REMU: short_res = bus.op_a_i;
      default: short_res = '0;
    endcase
  end

  assign accept = (state == S_IDLE) && bus.start_i && !bus.flush_i;

  rv32m_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i    (clk_i),
    .load     (accept),
    .step     (state == S_ITER),
    .is_div   (f3_q[2]),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_next (acc_next)
  );

  // Sign fix-up reads the core's post-step value so the result lands in the DONE cycle.
  always_comb begin
    prod = neg_res_q ? -acc_next : acc_next;
    case (f3_q)
      F3_MUL:                      final_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             final_res = neg_res_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      default:                     final_res = neg_rem_q ? -acc_next[2*XLEN-1:XLEN]
                                                         : acc_next[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      count      <= '0;
      f3_q       <= F3_MUL;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      stage_q    <= '0;
      stage_rd_q <= '0;
      result_q   <= '0;
      rd_hold_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          f3_q       <= bus.funct3_i;
          neg_res_q  <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          stage_rd_q <= bus.rd_i;
          if (div_zero || div_ovf) begin
            state   <= S_DONE;
            stage_q <= short_res;
          end else begin
            state <= S_ITER;
            count <= CW'(XLEN - 1);
          end
        end
        S_ITER: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else if (count == '0) begin
            state   <= S_DONE;
            stage_q <= final_res;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!bus.flush_i) begin
            result_q  <= stage_q;
            rd_hold_q <= stage_rd_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A flush in the DONE cycle suppresses the pulse and keeps the previously held result visible.
  assign bus.stall_o  = accept || (state == S_ITER);
  assign bus.busy_o   = (state != S_IDLE);
  assign bus.done_o   = (state == S_DONE) && !bus.flush_i;
  assign bus.result_o = bus.done_o ? stage_q : result_q;
  assign bus.rd_o     = bus.done_o ? stage_rd_q : rd_hold_q;

endmodule
